// File: rtl/de_scoreboard_if.sv
// Issue / retire / flush bundle between decode+retire logic and the scoreboard.
// master: decode/retire side (drives requests, reads ready and operands)
// slave : scoreboard (drives issue_ready, rdata1, rdata2)
interface de_scoreboard_if #(
    parameter int unsigned DBITS     = 32,
    parameter int unsigned REGNOBITS = 5,
    parameter int unsigned NRET      = 2
);
    logic                      issue_valid;
    logic [REGNOBITS-1:0]      issue_rs1;
    logic [REGNOBITS-1:0]      issue_rs2;
    logic                      issue_rs1_rd;
    logic                      issue_rs2_rd;
    logic                      issue_wr;
    logic [REGNOBITS-1:0]      issue_rd;
    logic                      issue_ready;
    logic [DBITS-1:0]          rdata1;
    logic [DBITS-1:0]          rdata2;
    logic [NRET-1:0]           ret_valid;
    logic [NRET*REGNOBITS-1:0] ret_rd;
    logic [NRET*DBITS-1:0]     ret_data;
    logic                      flush;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_rd, issue_rs2_rd,
               issue_wr, issue_rd, ret_valid, ret_rd, ret_data, flush,
        input  issue_ready, rdata1, rdata2
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_rd, issue_rs2_rd,
               issue_wr, issue_rd, ret_valid, ret_rd, ret_data, flush,
        output issue_ready, rdata1, rdata2
    );
endinterface

// File: rtl/de_scoreboard.sv
// Register scoreboard with register file, retire bypass and per-register
// in-flight writer counters.
// Ports: clk, reset (async active-low), bus (issue/retire/flush, slave side),
//        busy (per-register counter nonzero), stall_cnt (saturating stalled
//        cycles), err_underflow (sticky retire on idle register).
module de_scoreboard #(
    parameter int unsigned DBITS     = 32,
    parameter int unsigned REGWORDS  = 32,
    parameter int unsigned REGNOBITS = 5,
    parameter int unsigned NRET      = 2,
    parameter int unsigned CNTBITS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    de_scoreboard_if.slave      bus,
    output logic [REGWORDS-1:0] busy,
    output logic [15:0]         stall_cnt,
    output logic                err_underflow
);
    localparam int unsigned HITBITS = $clog2(NRET + 1);
    localparam logic [CNTBITS-1:0] CNT_MAX = '1;

    logic [CNTBITS-1:0] cnt_q  [REGWORDS];
    logic [CNTBITS-1:0] cnt_d  [REGWORDS];
    logic [DBITS-1:0]   regs_q [REGWORDS];
    logic [DBITS-1:0]   regs_d [REGWORDS];
    logic [HITBITS-1:0] hits   [REGWORDS];
    logic [15:0]        stall_q, stall_d;
    logic               err_q, err_d;
    logic               haz1, haz2, hazd, fire;

    // Number of retire ports targeting each register this cycle
    always_comb begin
        for (int unsigned r = 0; r < REGWORDS; r++) begin
            hits[r] = '0;
            for (int unsigned i = 0; i < NRET; i++) begin
                if (bus.ret_valid[i] && bus.ret_rd[i*REGNOBITS +: REGNOBITS] == REGNOBITS'(r))
                    hits[r] = hits[r] + HITBITS'(1);
            end
        end
    end

    // Hazards: sources see same-cycle retires, destination does not
    always_comb begin
        haz1 = bus.issue_rs1_rd && (bus.issue_rs1 != '0) &&
               (int'(cnt_q[bus.issue_rs1]) > int'(hits[bus.issue_rs1]));
        haz2 = bus.issue_rs2_rd && (bus.issue_rs2 != '0) &&
               (int'(cnt_q[bus.issue_rs2]) > int'(hits[bus.issue_rs2]));
        hazd = bus.issue_wr && (bus.issue_rd != '0) && (cnt_q[bus.issue_rd] == CNT_MAX);
        bus.issue_ready = !(haz1 || haz2 || hazd || bus.flush);
        fire = bus.issue_valid && bus.issue_ready;
    end

    // Operand read with bypass from retire ports; highest port wins
    always_comb begin
        bus.rdata1 = regs_q[bus.issue_rs1];
        bus.rdata2 = regs_q[bus.issue_rs2];
        for (int unsigned i = 0; i < NRET; i++) begin
            if (bus.ret_valid[i] && bus.issue_rs1 != '0 &&
                bus.ret_rd[i*REGNOBITS +: REGNOBITS] == bus.issue_rs1)
                bus.rdata1 = bus.ret_data[i*DBITS +: DBITS];
            if (bus.ret_valid[i] && bus.issue_rs2 != '0 &&
                bus.ret_rd[i*REGNOBITS +: REGNOBITS] == bus.issue_rs2)
                bus.rdata2 = bus.ret_data[i*DBITS +: DBITS];
        end
    end

    // Next-state: register file, counters, stall counter, underflow flag
    always_comb begin
        int base;
        base    = 0;
        regs_d  = regs_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall_d = stall_q;

        for (int unsigned i = 0; i < NRET; i++) begin
            if (bus.ret_valid[i] && bus.ret_rd[i*REGNOBITS +: REGNOBITS] != '0)
                regs_d[bus.ret_rd[i*REGNOBITS +: REGNOBITS]] = bus.ret_data[i*DBITS +: DBITS];
        end
        regs_d[0] = '0;

        cnt_d[0] = '0;
        for (int unsigned r = 1; r < REGWORDS; r++) begin
            base = int'(cnt_q[r]);
            if (fire && bus.issue_wr && bus.issue_rd == REGNOBITS'(r))
                base = base + 1;
            if (int'(hits[r]) > base) begin
                err_d    = 1'b1;
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = CNTBITS'(base - int'(hits[r]));
            end
            if (bus.flush)
                cnt_d[r] = '0;
        end

        if (bus.issue_valid && !bus.issue_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < REGWORDS; r++) begin
                cnt_q[r]  <= '0;
                regs_q[r] <= '0;
            end
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < REGWORDS; r++)
            busy[r] = (cnt_q[r] != '0);
    end

    assign stall_cnt     = stall_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_de_scoreboard.sv
// Scoreboard bench for de_scoreboard: directed scenarios plus random traffic,
// predicted by an array-based model and checked by an independent monitor.
module tb_de_scoreboard;
    logic        clk;
    logic        rst_n;
    logic [31:0] busy;
    logic [15:0] stall_cnt;
    logic        err_underflow;

    de_scoreboard_if #(.DBITS(32), .REGNOBITS(5), .NRET(2)) bus ();

    de_scoreboard dut (
        .clk          (clk),
        .reset        (rst_n),
        .bus          (bus.slave),
        .busy         (busy),
        .stall_cnt    (stall_cnt),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_rd;
        logic        rs2_rd;
        logic        wr;
        logic [4:0]  rd;
        logic [1:0]  rv;
        logic [9:0]  rrd;
        logic [63:0] rdat;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] busy;
        logic [15:0] stall;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    int          m_cnt [32];
    logic [31:0] m_reg [32];
    int          m_stall;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            m_reg[r] = 32'h0;
        end
        m_stall = 0;
        m_err   = 1'b0;
    endtask

    // Drive one cycle, predict outputs from model, then advance model
    task automatic step(input stim_t s);
        int   h [32];
        exp_t e;
        bit   fire;
        int   base;
        @(posedge clk);
        #1;
        rst_n            = s.rst_n;
        bus.issue_valid  = s.valid;
        bus.issue_rs1    = s.rs1;
        bus.issue_rs2    = s.rs2;
        bus.issue_rs1_rd = s.rs1_rd;
        bus.issue_rs2_rd = s.rs2_rd;
        bus.issue_wr     = s.wr;
        bus.issue_rd     = s.rd;
        bus.ret_valid    = s.rv;
        bus.ret_rd       = s.rrd;
        bus.ret_data     = s.rdat;
        bus.flush        = s.flush;
        if (!s.rst_n) model_clear();

        for (int r = 0; r < 32; r++) h[r] = 0;
        for (int p = 0; p < 2; p++)
            if (s.rv[p]) h[s.rrd[p*5 +: 5]]++;

        e.ready = !s.flush;
        if (s.rs1_rd && s.rs1 != 0 && m_cnt[s.rs1] - h[s.rs1] > 0) e.ready = 1'b0;
        if (s.rs2_rd && s.rs2 != 0 && m_cnt[s.rs2] - h[s.rs2] > 0) e.ready = 1'b0;
        if (s.wr && s.rd != 0 && m_cnt[s.rd] == 3) e.ready = 1'b0;

        e.r1 = m_reg[s.rs1];
        e.r2 = m_reg[s.rs2];
        for (int p = 0; p < 2; p++) begin
            if (s.rv[p] && s.rs1 != 0 && s.rrd[p*5 +: 5] == s.rs1) e.r1 = s.rdat[p*32 +: 32];
            if (s.rv[p] && s.rs2 != 0 && s.rrd[p*5 +: 5] == s.rs2) e.r2 = s.rdat[p*32 +: 32];
        end
        for (int r = 0; r < 32; r++) e.busy[r] = (m_cnt[r] != 0);
        e.stall = 16'(m_stall);
        e.err   = m_err;
        expq.push_back(e);

        if (s.rst_n) begin
            fire = s.valid && e.ready;
            for (int p = 0; p < 2; p++)
                if (s.rv[p] && s.rrd[p*5 +: 5] != 0) m_reg[s.rrd[p*5 +: 5]] = s.rdat[p*32 +: 32];
            for (int r = 1; r < 32; r++) begin
                base = m_cnt[r] + ((fire && s.wr && s.rd == r) ? 1 : 0);
                if (h[r] > base) m_err = 1'b1;
                if (s.flush)        m_cnt[r] = 0;
                else if (h[r] > base) m_cnt[r] = 0;
                else                m_cnt[r] = base - h[r];
            end
            if (s.valid && !e.ready && m_stall < 65535) m_stall++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("issue_ready", 64'(bus.issue_ready), 64'(e.ready));
            chk("rdata1", 64'(bus.rdata1), 64'(e.r1));
            chk("rdata2", 64'(bus.rdata2), 64'(e.r2));
            chk("busy", 64'(busy), 64'(e.busy));
            chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
            chk("err_underflow", 64'(err_underflow), 64'(e.err));
        end
    end

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        step(s);
    endtask

    stim_t s;

    initial begin
        rst_n            = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_rs1    = '0;
        bus.issue_rs2    = '0;
        bus.issue_rs1_rd = 1'b0;
        bus.issue_rs2_rd = 1'b0;
        bus.issue_wr     = 1'b0;
        bus.issue_rd     = '0;
        bus.ret_valid    = '0;
        bus.ret_rd       = '0;
        bus.ret_data     = '0;
        bus.flush        = 1'b0;
        model_clear();

        // Reset state
        do_reset();
        settle();
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_ready", 64'(bus.issue_ready), 64'h1);

        // RAW stall on x5
        s = idle(); s.valid = 1; s.wr = 1; s.rd = 5; step(s);
        s = idle(); s.valid = 1; s.rs1 = 5; s.rs1_rd = 1; step(s);
        settle();
        chk("raw_ready", 64'(bus.issue_ready), 64'h0);
        chk("raw_busy5", 64'(busy[5]), 64'h1);
        step(idle());
        settle();
        chk("raw_stall", 64'(stall_cnt), 64'h1);

        // Retire on port 1 bypasses into a waiting reader
        s = idle(); s.valid = 1; s.rs1 = 5; s.rs1_rd = 1;
        s.rv = 2'b10; s.rrd[9:5] = 5; s.rdat[63:32] = 32'hDEAD_BEEF; step(s);
        settle();
        chk("byp_ready", 64'(bus.issue_ready), 64'h1);
        chk("byp_rdata1", 64'(bus.rdata1), 64'hDEAD_BEEF);
        step(idle());
        settle();
        chk("byp_busy5", 64'(busy[5]), 64'h0);

        // Counter saturation on x7
        for (int k = 0; k < 3; k++) begin
            s = idle(); s.valid = 1; s.wr = 1; s.rd = 7; step(s);
        end
        s = idle(); s.valid = 1; s.wr = 1; s.rd = 7; step(s);
        settle();
        chk("waw_full", 64'(bus.issue_ready), 64'h0);
        s.rv = 2'b01; s.rrd[4:0] = 7; s.rdat[31:0] = 32'h77; step(s);
        settle();
        chk("waw_full_retire", 64'(bus.issue_ready), 64'h0);
        s = idle(); s.valid = 1; s.wr = 1; s.rd = 7; step(s);
        settle();
        chk("waw_after_retire", 64'(bus.issue_ready), 64'h1);

        // Dual retire collision on x3
        do_reset();
        for (int k = 0; k < 2; k++) begin
            s = idle(); s.valid = 1; s.wr = 1; s.rd = 3; step(s);
        end
        s = idle(); s.rv = 2'b11; s.rrd = {5'd3, 5'd3}; s.rdat = {32'd2, 32'd1}; step(s);
        s = idle(); s.valid = 1; s.rs1 = 3; s.rs1_rd = 1; step(s);
        settle();
        chk("coll_rdata", 64'(bus.rdata1), 64'd2);
        chk("coll_busy3", 64'(busy[3]), 64'h0);

        // Flush, then late retire underflows but still writes
        do_reset();
        s = idle(); s.valid = 1; s.wr = 1; s.rd = 9; step(s);
        s = idle(); s.flush = 1; s.valid = 1; step(s);
        settle();
        chk("flush_ready", 64'(bus.issue_ready), 64'h0);
        s = idle(); s.rv = 2'b01; s.rrd[4:0] = 9; s.rdat[31:0] = 32'h1234; step(s);
        s = idle(); s.valid = 1; s.rs1 = 9; s.rs1_rd = 1; step(s);
        settle();
        chk("uf_err", 64'(err_underflow), 64'h1);
        chk("uf_busy9", 64'(busy[9]), 64'h0);
        chk("uf_rdata", 64'(bus.rdata1), 64'h1234);

        // x0 never hazards
        s = idle(); s.valid = 1; s.wr = 1; s.rd = 0; s.rs1_rd = 1; s.rs2_rd = 1; step(s);
        step(s);
        settle();
        chk("x0_ready", 64'(bus.issue_ready), 64'h1);
        chk("x0_rdata", 64'({bus.rdata1, bus.rdata2}), 64'h0);
        chk("x0_busy", 64'(busy[0]), 64'h0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.valid  = ($urandom % 4) != 0;
            s.rs1    = 5'($urandom % 8);
            s.rs2    = 5'($urandom % 8);
            s.rs1_rd = $urandom % 2;
            s.rs2_rd = $urandom % 2;
            s.wr     = ($urandom % 3) != 0;
            s.rd     = 5'($urandom % 8);
            for (int p = 0; p < 2; p++) begin
                int r;
                r = int'($urandom % 8);
                if (($urandom % 3) == 0 && (m_cnt[r] > 0 || ($urandom % 16) == 0)) begin
                    s.rv[p] = 1'b1;
                    s.rrd[p*5 +: 5] = 5'(r);
                    s.rdat[p*32 +: 32] = $urandom;
                end
            end
            s.flush = ($urandom % 60) == 0;
            s.rst_n = ($urandom % 400) != 0;
            step(s);
        end
        step(idle());
        settle();
        chk("queue_drained", 64'(expq.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/de_scoreboard.md
DE_SCOREBOARD -- requirements
Module: de_scoreboard

Interface
REQ-001 Parameters SHALL be: DBITS, default 32, data width; REGWORDS, default 32, register count; REGNOBITS, default 5, register index width; NRET, default 2, retire ports; CNTBITS, default 2, per-register in-flight counter width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 issue_valid  input  1  decode presents an instruction.
REQ-005 issue_rs1, issue_rs2  input  REGNOBITS each  source register indices.
REQ-006 issue_rs1_rd, issue_rs2_rd  input  1 each  source actually read.
REQ-007 issue_wr, issue_rd  input  1, REGNOBITS  instruction writes register issue_rd.
REQ-008 issue_ready  output  1  no hazard; issue fires when issue_valid && issue_ready.
REQ-009 rdata1, rdata2  output  DBITS each  source operand values, combinational.
REQ-010 ret_valid  input  NRET  per-port retire strobe.
REQ-011 ret_rd, ret_data  input  NRET*REGNOBITS, NRET*DBITS  port i in slice i.
REQ-012 flush  input  1  squash all in-flight writers.
REQ-013 busy  output  REGWORDS  bit r = counter r nonzero.
REQ-014 stall_cnt  output  16  saturating count of stalled cycles.
REQ-015 err_underflow  output  1  sticky retire-on-idle-register error.

Function
REQ-016 Register file of REGWORDS x DBITS SHALL be written on posedge when ret_valid[i] and ret_rd[i] != 0; on same-cycle same-rd collision the highest port index SHALL win.
REQ-017 Register 0 SHALL read 0, never be busy, and never be counted or written.
REQ-018 rdata1/2 SHALL bypass: if any ret_valid[i] with ret_rd[i] equal to the source index (nonzero), output the highest-index matching ret_data; else the register file value.
REQ-019 Per-register counter cnt[r] (CNTBITS) SHALL count issued-but-unretired writers, allowing WAW overlap.
REQ-020 Source hazard SHALL exist when its read enable is set, index nonzero, and cnt[index] minus the number of retire ports matching index this cycle is nonzero.
REQ-021 Destination hazard SHALL exist when issue_wr, issue_rd != 0 and cnt[issue_rd] equals 2^CNTBITS-1, regardless of same-cycle retires.
REQ-022 issue_ready SHALL equal NOT(any source hazard OR destination hazard OR flush).
REQ-023 Next cnt[r] SHALL be cnt[r] + (issue fire with issue_wr and issue_rd==r) - (number of ret_valid ports with ret_rd==r), applied in one cycle.
REQ-024 A decrement that would go below 0 SHALL clamp at 0 and set err_underflow, which holds until reset.
REQ-025 flush SHALL zero all counters next cycle, block issue that cycle, and still perform that cycle's register file writes.
REQ-026 stall_cnt SHALL increment each cycle with issue_valid && !issue_ready, saturating at 16'hFFFF.
REQ-027 busy SHALL reflect registered counter state (no same-cycle retire look-ahead).

Reset
REQ-028 When reset is low: all registers, all counters, stall_cnt and err_underflow SHALL clear to 0 asynchronously; busy = 0, issue_ready = 1 when issue_valid with no flush.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight state; no retirement SHALL be recorded during reset.

Verification
REQ-030 Issue wr x5, then issue reading x5 next cycle with no retire -> issue_ready=0, busy[5]=1, stall_cnt=1.
REQ-031 x5 cnt=1, port 1 retires x5=32'hDEAD_BEEF while issue reads x5 -> issue_ready=1, rdata1=32'hDEAD_BEEF, cnt[5]=0 next cycle.
REQ-032 Three back-to-back writers to x7 (CNTBITS=2) -> fourth writer stalls at cnt=3; one retire -> next writer issues.
REQ-033 Ports 0 and 1 retire x3 with 1 and 2 same cycle -> x3 reads 2; cnt[3] decremented by 2.
REQ-034 Issue wr x9, flush next cycle, then retire x9 -> cnt[9]=0, err_underflow=1, x9 written.
REQ-035 Issue wr x0, read x0 -> never stalls, rdata=0, busy[0]=0.
